// File: rtl/riscv_pipe_cpu.sv
// riscv_pipe_cpu: five-stage in-order RV32 integer pipeline (IF/ID/EX/MEM/WB).
// The instruction memory, data memory and register file are internal arrays
// (imem, dmem, regs); the bench loads them. Supported: add, sub, and, xor,
// sll, mul, addi, srai, lw, sw, beq; any other encoding retires as a NOP.
//
// Ports:
//   clk_i    in   1   clock, rising edge
//   rst_i    in   1   asynchronous active-high reset (pipeline and PC only)
//   start_i  in   1   run enable; low freezes the PC and lets the pipe drain
//   pc_o     out  32  current PC register
//   stall_o  out  1   load-use bubble inserted this cycle
//   flush_o  out  1   taken beq flushing IF/ID this cycle
module riscv_pipe_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] pc_o,
  output logic        stall_o,
  output logic        flush_o
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_BYTES);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_e;

  logic [31:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] regs [32];

  logic [31:0] pc, ifid_instr, ifid_pc;
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_use_imm;
  alu_op_e     idex_alu;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [31:0] idex_a, idex_b, idex_imm;
  logic        exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu, exmem_store;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_use_imm, dec_branch;
  alu_op_e     dec_alu;
  logic [31:0] dec_imm, rd1, rd2;
  logic        branch_taken, hazard;
  logic [31:0] fwd_a, fwd_b, op_b, alu_y, mem_rdata;
  logic [DW-1:0] maddr;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign funct3 = ifid_instr[14:12];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];
  assign funct7 = ifid_instr[31:25];
  assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                   ifid_instr[30:25], ifid_instr[11:8], 1'b0};

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_use_imm   = 1'b0;
    dec_branch    = 1'b0;
    dec_alu       = ALU_ADD;
    dec_imm       = imm_i;
    case (opcode)
      7'b0110011: begin
        dec_reg_write = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_alu = ALU_ADD;
          {7'b0100000, 3'b000}: dec_alu = ALU_SUB;
          {7'b0000000, 3'b100}: dec_alu = ALU_XOR;
          {7'b0000000, 3'b111}: dec_alu = ALU_AND;
          {7'b0000000, 3'b001}: dec_alu = ALU_SLL;
          {7'b0000001, 3'b000}: dec_alu = ALU_MUL;
          default:              dec_reg_write = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_use_imm = 1'b1;
        if (funct3 == 3'b000) begin
          dec_reg_write = 1'b1;
        end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
          dec_reg_write = 1'b1;
          dec_alu       = ALU_SRA;
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          dec_reg_write = 1'b1;
          dec_mem_read  = 1'b1;
          dec_use_imm   = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          dec_mem_write = 1'b1;
          dec_use_imm   = 1'b1;
          dec_imm       = imm_s;
        end
      end
      7'b1100011: dec_branch = (funct3 == 3'b000);
      default: ;
    endcase
  end

  // Register read with WB bypass so a same-cycle writeback is seen by ID.
  always_comb begin
    rd1 = regs[rs1];
    rd2 = regs[rs2];
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1) rd1 = memwb_data;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2) rd2 = memwb_data;
    if (rs1 == 5'd0) rd1 = 32'd0;
    if (rs2 == 5'd0) rd2 = 32'd0;
  end

  // A taken branch wins over a load-use hazard in the same cycle.
  assign branch_taken = dec_branch && (rd1 == rd2);
  assign hazard  = idex_mem_read && idex_rd != 5'd0 && (idex_rd == rs1 || idex_rd == rs2);
  assign flush_o = branch_taken;
  assign stall_o = hazard && !branch_taken;
  assign pc_o    = pc;

  // With start_i low the PC freezes and IF injects bubbles so the pipe drains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc         <= 32'd0;
      ifid_instr <= 32'd0;
      ifid_pc    <= 32'd0;
    end else if (branch_taken) begin
      pc         <= ifid_pc + imm_b;
      ifid_instr <= 32'd0;
    end else if (stall_o) begin
      pc         <= pc;
    end else if (start_i) begin
      pc         <= pc + 32'd4;
      ifid_instr <= imem[pc[IW+1:2]];
      ifid_pc    <= pc;
    end else begin
      ifid_instr <= 32'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_reg_write <= 1'b0;
      idex_mem_read  <= 1'b0;
      idex_mem_write <= 1'b0;
      idex_use_imm   <= 1'b0;
      idex_alu       <= ALU_ADD;
      idex_rs1       <= 5'd0;
      idex_rs2       <= 5'd0;
      idex_rd        <= 5'd0;
      idex_a         <= 32'd0;
      idex_b         <= 32'd0;
      idex_imm       <= 32'd0;
    end else begin
      idex_reg_write <= dec_reg_write && !stall_o;
      idex_mem_read  <= dec_mem_read && !stall_o;
      idex_mem_write <= dec_mem_write && !stall_o;
      idex_use_imm   <= dec_use_imm;
      idex_alu       <= dec_alu;
      idex_rs1       <= rs1;
      idex_rs2       <= rs2;
      idex_rd        <= rd;
      idex_a         <= rd1;
      idex_b         <= rd2;
      idex_imm       <= dec_imm;
    end
  end

  // EX/MEM has priority over MEM/WB because it holds the younger result.
  always_comb begin
    fwd_a = idex_a;
    fwd_b = idex_b;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1) fwd_a = exmem_alu;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1) fwd_a = memwb_data;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2) fwd_b = exmem_alu;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2) fwd_b = memwb_data;
    op_b  = idex_use_imm ? idex_imm : fwd_b;
    alu_y = fwd_a + op_b;
    case (idex_alu)
      ALU_SUB: alu_y = fwd_a - op_b;
      ALU_AND: alu_y = fwd_a & op_b;
      ALU_XOR: alu_y = fwd_a ^ op_b;
      ALU_SLL: alu_y = fwd_a << op_b[4:0];
      ALU_SRA: alu_y = $signed(fwd_a) >>> op_b[4:0];
      ALU_MUL: alu_y = fwd_a * op_b;
      default: alu_y = fwd_a + op_b;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_rd        <= 5'd0;
      exmem_alu       <= 32'd0;
      exmem_store     <= 32'd0;
    end else begin
      exmem_reg_write <= idex_reg_write;
      exmem_mem_read  <= idex_mem_read;
      exmem_mem_write <= idex_mem_write;
      exmem_rd        <= idex_rd;
      exmem_alu       <= alu_y;
      exmem_store     <= fwd_b;
    end
  end

  // Byte address wraps modulo DMEM_BYTES, including within a word.
  assign maddr     = exmem_alu[DW-1:0];
  assign mem_rdata = {dmem[maddr + DW'(3)], dmem[maddr + DW'(2)],
                      dmem[maddr + DW'(1)], dmem[maddr]};

  always_ff @(posedge clk_i) begin
    if (exmem_mem_write) begin
      dmem[maddr]          <= exmem_store[7:0];
      dmem[maddr + DW'(1)] <= exmem_store[15:8];
      dmem[maddr + DW'(2)] <= exmem_store[23:16];
      dmem[maddr + DW'(3)] <= exmem_store[31:24];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memwb_reg_write <= 1'b0;
      memwb_rd        <= 5'd0;
      memwb_data      <= 32'd0;
    end else begin
      memwb_reg_write <= exmem_reg_write;
      memwb_rd        <= exmem_rd;
      memwb_data      <= exmem_mem_read ? mem_rdata : exmem_alu;
    end
  end

  always_ff @(posedge clk_i) begin
    if (memwb_reg_write && memwb_rd != 5'd0) regs[memwb_rd] <= memwb_data;
  end
endmodule

// File: tb/tb_riscv_pipe_cpu.sv
// tb_riscv_pipe_cpu: directed programs for riscv_pipe_cpu with hand-computed
// register, memory and stall/flush expectations.
module tb_riscv_pipe_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_o;
  logic        stall_o, flush_o;

  int checks = 0;
  int failures = 0;
  int stall_count = 0;
  int flush_count = 0;
  logic [31:0] prog [32];
  int prog_len = 0;

  riscv_pipe_cpu #(.IMEM_WORDS(256), .DMEM_BYTES(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .pc_o(pc_o), .stall_o(stall_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encR(input logic [6:0] f7, input int rs2, input int rs1,
                                       input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] encAddi(input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] encSrai(input int rd, input int rs1, input int sh);
    return {7'b0100000, 5'(sh), 5'(rs1), 3'b101, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] encLw(input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] encSw(input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encBeq(input int rs1, input int rs2, input int off);
    logic [31:0] v;
    v = off;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)",
               tag, observed, $signed(observed), expected, $signed(expected));
    end
  endtask

  task automatic emit(input logic [31:0] ins);
    prog[prog_len] = ins;
    prog_len++;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) dut.regs[i] <= 32'd0;
    for (int i = 0; i < 32; i++) dut.dmem[i] <= 8'd0;
    for (int i = 0; i < 256; i++) dut.imem[i] <= 32'd0;
    prog_len = 0;
    stall_count = 0;
    flush_count = 0;
    @(negedge clk);
  endtask

  task automatic loadProgram();
    for (int i = 0; i < prog_len; i++) dut.imem[i] <= prog[i];
    @(negedge clk);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    #1;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (stall_o) stall_count++;
      if (flush_o) flush_count++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    resetDut();
    #1;
    checkOutput("reset_pc", pc_o, 32'd0);
    checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("reset_flush", {31'd0, flush_o}, 32'd0);

    // Back-to-back ALU dependences, x3 lands on the 7th edge
    $display("[TB] test 1: forwarding chain");
    resetDut();
    emit(encAddi(1, 0, 5));
    emit(encAddi(2, 1, 3));
    emit(encR(7'b0000000, 2, 1, 3'b000, 3));
    loadProgram();
    releaseReset();
    applyStimulus(6);
    checkOutput("t1_x3_before_edge7", dut.regs[3], 32'd0);
    applyStimulus(1);
    checkOutput("t1_x3_at_edge7", dut.regs[3], 32'd13);
    applyStimulus(5);
    checkOutput("t1_x1", dut.regs[1], 32'd5);
    checkOutput("t1_x2", dut.regs[2], 32'd8);
    checkOutput("t1_stalls", stall_count, 32'd0);
    checkOutput("t1_flushes", flush_count, 32'd0);

    // Load-use bubble
    $display("[TB] test 2: load-use");
    resetDut();
    dut.dmem[0] <= 8'd5;
    emit(encLw(1, 0, 0));
    emit(encR(7'b0000000, 1, 1, 3'b000, 2));
    loadProgram();
    releaseReset();
    applyStimulus(10);
    checkOutput("t2_stalls", stall_count, 32'd1);
    checkOutput("t2_x1", dut.regs[1], 32'd5);
    checkOutput("t2_x2", dut.regs[2], 32'd10);

    // Taken beq squashes the fall-through instruction
    $display("[TB] test 3: branch flush");
    resetDut();
    emit(encBeq(0, 0, 8));
    emit(encAddi(5, 0, 1));
    emit(encAddi(6, 0, 2));
    loadProgram();
    releaseReset();
    applyStimulus(8);
    checkOutput("t3_flushes", flush_count, 32'd1);
    checkOutput("t3_stalls", stall_count, 32'd0);
    checkOutput("t3_x5", dut.regs[5], 32'd0);
    checkOutput("t3_x6", dut.regs[6], 32'd2);

    // ALU operations on x1=-16, x2=3
    $display("[TB] test 4: alu ops");
    resetDut();
    emit(encAddi(1, 0, -16));
    emit(encAddi(2, 0, 3));
    emit(encR(7'b0000001, 2, 1, 3'b000, 3));
    emit(encR(7'b0100000, 2, 1, 3'b000, 4));
    emit(encR(7'b0000000, 2, 1, 3'b100, 5));
    emit(encR(7'b0000000, 2, 1, 3'b111, 6));
    emit(encR(7'b0000000, 2, 1, 3'b001, 7));
    emit(encSrai(8, 1, 2));
    loadProgram();
    releaseReset();
    applyStimulus(16);
    checkOutput("t4_mul", dut.regs[3], -48);
    checkOutput("t4_sub", dut.regs[4], -19);
    checkOutput("t4_xor", dut.regs[5], -13);
    checkOutput("t4_and", dut.regs[6], 32'd0);
    checkOutput("t4_sll", dut.regs[7], -128);
    checkOutput("t4_srai", dut.regs[8], -4);

    // Fibonacci loop: 5 back-branches + 1 exit branch, one load-use at the end
    $display("[TB] test 5: fibonacci");
    resetDut();
    dut.dmem[0] <= 8'd5;
    emit(encLw(1, 0, 0));
    emit(encAddi(2, 0, 0));
    emit(encAddi(3, 0, 1));
    emit(encAddi(4, 0, 0));
    emit(encBeq(1, 0, 24));
    emit(encR(7'b0000000, 3, 2, 3'b000, 4));
    emit(encR(7'b0000000, 0, 3, 3'b000, 2));
    emit(encR(7'b0000000, 0, 4, 3'b000, 3));
    emit(encAddi(1, 1, -1));
    emit(encBeq(0, 0, -20));
    emit(encSw(2, 0, 4));
    emit(encLw(7, 0, 4));
    emit(encR(7'b0000000, 7, 7, 3'b000, 8));
    loadProgram();
    releaseReset();
    applyStimulus(64);
    checkOutput("t5_mem_word4", {dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]}, 32'd5);
    checkOutput("t5_x2", dut.regs[2], 32'd5);
    checkOutput("t5_x8", dut.regs[8], 32'd10);
    checkOutput("t5_stalls", stall_count, 32'd1);
    checkOutput("t5_flushes", flush_count, 32'd6);

    // Mid-run async reset, x0 stays zero and is never forwarded
    $display("[TB] test 6: mid-run reset");
    resetDut();
    emit(encAddi(0, 0, 7));
    emit(encR(7'b0000000, 0, 0, 3'b000, 9));
    emit(encAddi(10, 0, 9));
    emit(encAddi(11, 0, 4));
    loadProgram();
    releaseReset();
    applyStimulus(3);
    checkOutput("t6_pc_before_reset", pc_o, 32'd12);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_pc_async_reset", pc_o, 32'd0);
    checkOutput("t6_flush_in_reset", {31'd0, flush_o}, 32'd0);
    stall_count = 0;
    flush_count = 0;
    releaseReset();
    applyStimulus(10);
    checkOutput("t6_x0", dut.regs[0], 32'd0);
    checkOutput("t6_x9", dut.regs[9], 32'd0);
    checkOutput("t6_x10", dut.regs[10], 32'd9);
    checkOutput("t6_x11", dut.regs[11], 32'd4);
    checkOutput("t6_stalls", stall_count, 32'd0);
    checkOutput("t6_flushes", flush_count, 32'd0);

    // start_i dropped: PC freezes, fetched instructions still retire
    $display("[TB] test 7: start_i freeze");
    resetDut();
    emit(encAddi(1, 0, 1));
    emit(encAddi(2, 0, 2));
    emit(encAddi(3, 0, 3));
    loadProgram();
    releaseReset();
    applyStimulus(2);
    start = 1'b0;
    applyStimulus(8);
    checkOutput("t7_pc_frozen", pc_o, 32'd8);
    checkOutput("t7_x1", dut.regs[1], 32'd1);
    checkOutput("t7_x2", dut.regs[2], 32'd2);
    checkOutput("t7_x3", dut.regs[3], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
